// File: rtl/can_resp_pkg.sv
// Shared types and helpers for the CAN sequence responder: FSM states,
// received-frame field layout and a saturating counter increment.
package can_resp_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_BACKOFF} tx_state_t;

  localparam int FRAME_W  = 80;
  localparam int ID_LSB   = 68;
  localparam int ID_W     = 11;
  localparam int DLC_LSB  = 64;
  localparam int DLC_W    = 4;
  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 64;

  localparam logic [7:0] RSP_TRAILER = 8'hA5;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/can_seq_responder_if.sv
// Receive strobe and transmit request/handshake bundle between the responder
// and the CAN controller.
interface can_seq_responder_if;
  import can_resp_pkg::*;

  logic [FRAME_W-1:0] rx_data;
  logic               rx_dvalid;
  logic [ID_W-1:0]    tx_id;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_start_strobe;
  logic               tx_succeed;
  logic               tx_failed;

  modport slave  (input  rx_data, rx_dvalid, tx_succeed, tx_failed,
                  output tx_id, tx_data, tx_start_strobe);
  modport master (output rx_data, rx_dvalid, tx_succeed, tx_failed,
                  input  tx_id, tx_data, tx_start_strobe);
endinterface

// File: rtl/can_resp_tx_ctrl.sv
// Response transmit sequencer: pulls the pending payload, strobes the CAN
// controller and retries failed frames after a fixed backoff.
module can_resp_tx_ctrl
  import can_resp_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pending,
  input  logic [DATA_W-1:0] pend_data,
  output logic              take,
  output logic              give_up,
  input  logic              tx_succeed,
  input  logic              tx_failed,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start_strobe
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP + 1) : 1;

  tx_state_t     state;
  logic [RW-1:0] retry;
  logic [GW-1:0] gap;
  logic          last_try;

  assign last_try = (retry == RW'(MAX_RETRY));
  assign take     = (state == ST_IDLE) && pending;
  // Simultaneous succeed/fail is a success, so it never exhausts retries.
  assign give_up  = (state == ST_WAIT) && tx_failed && !tx_succeed && last_try;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      retry           <= '0;
      gap             <= '0;
      tx_data         <= '0;
      tx_start_strobe <= 1'b0;
    end else begin
      tx_start_strobe <= 1'b0;
      case (state)
        ST_IDLE: if (pending) begin
          tx_data         <= pend_data;
          retry           <= '0;
          tx_start_strobe <= 1'b1;
          state           <= ST_START;
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          if (tx_succeed) begin
            state <= ST_IDLE;
          end else if (tx_failed) begin
            if (last_try) begin
              state <= ST_IDLE;
            end else begin
              retry <= retry + RW'(1);
              gap   <= '0;
              state <= ST_BACKOFF;
            end
          end
        end
        ST_BACKOFF: begin
          if (gap == GW'(RETRY_GAP - 1)) begin
            tx_start_strobe <= 1'b1;
            state           <= ST_START;
          end else begin
            gap <= gap + GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/can_seq_responder.sv
// Far-end checker for the periodic CAN count frame: validates format and
// sequence, keeps error counters and a link watchdog, and answers each frame.
module can_seq_responder
  import can_resp_pkg::*;
#(
  parameter logic [ID_W-1:0] MATCH_ID       = 11'h352,
  parameter logic [ID_W-1:0] RESP_ID        = 11'h353,
  parameter int              MAX_RETRY      = 3,
  parameter int              RETRY_GAP      = 1000,
  parameter int              TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  can_seq_responder_if.slave  bus,
  output logic [15:0]         seq_ok_cnt,
  output logic [15:0]         seq_err_cnt,
  output logic [15:0]         fmt_err_cnt,
  output logic [15:0]         rsp_drop_cnt,
  output logic [7:0]          last_seq,
  output logic                link_alive
);

  localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [ID_W-1:0]   id;
  logic [DLC_W-1:0]  dlc;
  logic [DATA_W-1:0] data;
  logic [7:0]        byte0;
  logic              same, match, good, bad_fmt, in_seq;
  logic [15:0]       ok_nxt, err_nxt, drop_one, drop_nxt;
  logic [DATA_W-1:0] rsp, pend_data;
  logic              have_seq, pending, take, give_up, overwrite;
  logic [WDW-1:0]    wd;
  // Bit 79 is reserved in the frame format and deliberately ignored.
  logic              unused_rsvd;

  assign id          = bus.rx_data[ID_LSB +: ID_W];
  assign dlc         = bus.rx_data[DLC_LSB +: DLC_W];
  assign data        = bus.rx_data[DATA_LSB +: DATA_W];
  assign byte0       = data[7:0];
  assign unused_rsvd = bus.rx_data[FRAME_W-1];
  assign bus.tx_id   = RESP_ID;

  always_comb begin
    same = 1'b1;
    for (int i = 1; i < 8; i++)
      if (data[8*i +: 8] != byte0) same = 1'b0;
  end

  assign match     = bus.rx_dvalid && (id == MATCH_ID);
  assign good      = match && (dlc == 4'd8) && same;
  assign bad_fmt   = match && !good;
  assign in_seq    = !have_seq || (byte0 == last_seq + 8'd1);
  assign ok_nxt    = (good && in_seq)  ? sat_inc(seq_ok_cnt)  : seq_ok_cnt;
  assign err_nxt   = (good && !in_seq) ? sat_inc(seq_err_cnt) : seq_err_cnt;
  assign rsp       = {byte0, ~byte0, ok_nxt, err_nxt, fmt_err_cnt[7:0], RSP_TRAILER};
  assign overwrite = good && pending && !take;
  assign drop_one  = (overwrite || give_up) ? sat_inc(rsp_drop_cnt) : rsp_drop_cnt;
  assign drop_nxt  = (overwrite && give_up) ? sat_inc(drop_one) : drop_one;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_ok_cnt   <= '0;
      seq_err_cnt  <= '0;
      fmt_err_cnt  <= '0;
      rsp_drop_cnt <= '0;
      last_seq     <= '0;
      link_alive   <= 1'b0;
      have_seq     <= 1'b0;
      pending      <= 1'b0;
      pend_data    <= '0;
      wd           <= '0;
    end else begin
      seq_ok_cnt   <= ok_nxt;
      seq_err_cnt  <= err_nxt;
      rsp_drop_cnt <= drop_nxt;
      if (bad_fmt) fmt_err_cnt <= sat_inc(fmt_err_cnt);

      if (good) begin
        pending   <= 1'b1;
        pend_data <= rsp;
      end else if (take) begin
        pending <= 1'b0;
      end

      // A good frame in the expiry cycle keeps the link alive.
      if (good) begin
        last_seq   <= byte0;
        have_seq   <= 1'b1;
        link_alive <= 1'b1;
        wd         <= '0;
      end else if (link_alive) begin
        if (wd == WDW'(TIMEOUT_CYCLES - 1)) begin
          link_alive <= 1'b0;
          have_seq   <= 1'b0;
          wd         <= '0;
        end else begin
          wd <= wd + WDW'(1);
        end
      end
    end
  end

  can_resp_tx_ctrl #(
    .MAX_RETRY (MAX_RETRY),
    .RETRY_GAP (RETRY_GAP)
  ) u_tx_ctrl (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pending         (pending),
    .pend_data       (pend_data),
    .take            (take),
    .give_up         (give_up),
    .tx_succeed      (bus.tx_succeed),
    .tx_failed       (bus.tx_failed),
    .tx_data         (bus.tx_data),
    .tx_start_strobe (bus.tx_start_strobe)
  );

endmodule

// File: tb/tb_can_seq_responder.sv
// Directed plus randomized bench for can_seq_responder against a frame-level
// reference model (counters, sequence/link rules, expected response payloads).
module tb_can_seq_responder;

  localparam int          T   = 50;
  localparam int          RG  = 1000;
  localparam int          MR  = 3;
  localparam logic [10:0] MID = 11'h352;
  localparam logic [10:0] RID = 11'h353;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  can_seq_responder_if bus();
  logic [15:0] ok_c, err_c, fmt_c, drop_c;
  logic [7:0]  lseq;
  logic        alive;

  can_seq_responder #(
    .MAX_RETRY (MR), .RETRY_GAP (RG), .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_i (clk), .rst_i (rst), .bus (bus),
    .seq_ok_cnt (ok_c), .seq_err_cnt (err_c), .fmt_err_cnt (fmt_c),
    .rsp_drop_cnt (drop_c), .last_seq (lseq), .link_alive (alive)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         m_ok, m_err, m_fmt, m_drop, m_lastc;
  logic [7:0] m_last;
  bit         m_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ok = 0; m_err = 0; m_fmt = 0; m_drop = 0; m_lastc = 0;
    m_last = 8'h00; m_seen = 1'b0;
  endfunction

  function automatic bit model_alive(input int c);
    return m_seen && (c - m_lastc <= T);
  endfunction

  function automatic bit model_frame(input logic [10:0] id, input logic [3:0] dlc,
                                     input logic [63:0] d, input int fc,
                                     output logic [63:0] pay);
    logic [7:0] b;
    bit same;
    pay  = '0;
    b    = d[7:0];
    same = 1'b1;
    for (int i = 1; i < 8; i++) if (d[8*i +: 8] != b) same = 1'b0;
    if (id != MID) return 1'b0;
    if (dlc != 4'd8 || !same) begin m_fmt++; return 1'b0; end
    if (!model_alive(fc) || b == 8'(m_last + 8'd1)) m_ok++; else m_err++;
    m_last  = b;
    m_seen  = 1'b1;
    m_lastc = fc;
    pay = {b, ~b, 16'(m_ok), 16'(m_err), 8'(m_fmt), 8'hA5};
    return 1'b1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic [10:0] id, input logic [3:0] dlc,
                      input logic [63:0] d, output int fc);
    bus.rx_data   = {1'($urandom_range(0, 1)), id, dlc, d};
    bus.rx_dvalid = 1'b1;
    fc = cyc;
    @(negedge clk);
    bus.rx_dvalid = 1'b0;
  endtask

  task automatic wait_strobe(input int maxc, output bit got, output int sc,
                             output logic [63:0] sd);
    got = 1'b0; sc = -1; sd = '0;
    for (int i = 0; i < maxc; i++) begin
      if (bus.tx_start_strobe) begin got = 1'b1; sc = cyc; sd = bus.tx_data; break; end
      @(negedge clk);
    end
  endtask

  // Called in the strobe cycle; answers in the following (WAIT) cycle.
  task automatic respond(input string tag, input bit s, input bit f);
    @(negedge clk);
    chk({tag, "_strobe_1cyc"}, 64'(bus.tx_start_strobe), 64'd0);
    bus.tx_succeed = s;
    bus.tx_failed  = f;
    @(negedge clk);
    bus.tx_succeed = 1'b0;
    bus.tx_failed  = 1'b0;
  endtask

  task automatic expect_none(input string tag, input int n);
    bit got; int sc; logic [63:0] sd;
    wait_strobe(n, got, sc, sd);
    chk({tag, "_no_strobe"}, 64'(got), 64'd0);
  endtask

  task automatic check_cnt(input string tag);
    chk({tag, "_ok"},    64'(ok_c),   64'(16'(m_ok)));
    chk({tag, "_err"},   64'(err_c),  64'(16'(m_err)));
    chk({tag, "_fmt"},   64'(fmt_c),  64'(16'(m_fmt)));
    chk({tag, "_drop"},  64'(drop_c), 64'(16'(m_drop)));
    chk({tag, "_last"},  64'(lseq),   64'(m_last));
    chk({tag, "_alive"}, 64'(alive),  64'(model_alive(cyc)));
  endtask

  // Send one frame, then expect either a strobe at N+2 (answered with success) or silence.
  task automatic frame(input string tag, input logic [10:0] id, input logic [3:0] dlc,
                       input logic [63:0] d, output logic [63:0] sd);
    int fc, sc; bit q, got; logic [63:0] pay;
    send(id, dlc, d, fc);
    q = model_frame(id, dlc, d, fc, pay);
    sd = '0;
    if (q) begin
      wait_strobe(8, got, sc, sd);
      chk({tag, "_seen"}, 64'(got), 64'd1);
      if (got) begin
        chk({tag, "_lat"},  64'(sc), 64'(fc + 2));
        chk({tag, "_data"}, sd, pay);
        chk({tag, "_id"},   64'(bus.tx_id), 64'(RID));
        respond(tag, 1'b1, 1'b0);
      end
    end else begin
      expect_none(tag, 5);
    end
    check_cnt(tag);
  endtask

  initial begin
    #900_000;
    $display("FAIL global_timeout: still running at %0t, want finished", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0] sd, pay;
    int fc, sc, f_cyc, gap, errs;
    bit got;
    bus.rx_data = '0; bus.rx_dvalid = 1'b0;
    bus.tx_succeed = 1'b0; bus.tx_failed = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tx_data", bus.tx_data, 64'd0);
    chk("rst_strobe", 64'(bus.tx_start_strobe), 64'd0);
    check_cnt("rst");
    rst = 1'b0;

    // In-order frames after reset
    frame("s05", MID, 4'd8, {8{8'h05}}, sd);
    frame("s06", MID, 4'd8, {8{8'h06}}, sd);
    frame("s07", MID, 4'd8, {8{8'h07}}, sd);
    chk("s07_literal", sd, 64'h07F8_0003_0000_00A5);

    // Wrap and one break
    do_reset();
    frame("sFE", MID, 4'd8, {8{8'hFE}}, sd);
    frame("sFF", MID, 4'd8, {8{8'hFF}}, sd);
    frame("s00", MID, 4'd8, {8{8'h00}}, sd);
    frame("s02", MID, 4'd8, {8{8'h02}}, sd);
    chk("wrap_ok", 64'(ok_c), 64'd3);
    chk("wrap_err", 64'(err_c), 64'd1);

    // Malformed and foreign frames
    frame("dlc7", MID, 4'd7, {8{8'h03}}, sd);
    chk("dlc7_fmt", 64'(fmt_c), 64'd1);
    frame("b3diff", MID, 4'd8, 64'h0303_0303_1303_0303, sd);
    frame("other_id", 11'h100, 4'd8, {8{8'h03}}, sd);

    // Every attempt fails: 1 + MR strobes, then dropped
    send(MID, 4'd8, {8{8'h03}}, fc);
    void'(model_frame(MID, 4'd8, {8{8'h03}}, fc, pay));
    wait_strobe(8, got, sc, sd);
    chk("rty0_seen", 64'(got), 64'd1);
    chk("rty0_lat", 64'(sc), 64'(fc + 2));
    for (int r = 0; r <= MR; r++) begin
      f_cyc = sc + 1;
      respond("rty", 1'b0, 1'b1);
      if (r < MR) begin
        wait_strobe(RG + 20, got, sc, sd);
        gap = sc - f_cyc - 1;
        chk("rty_seen", 64'(got), 64'd1);
        chk("rty_gap", 64'(gap >= RG && gap <= RG + 2), 64'd1);
        chk("rty_data", sd, pay);
      end
    end
    m_drop++;
    expect_none("rty_done", RG + 20);
    check_cnt("rty_done");
    frame("after_rty", MID, 4'd8, {8{8'h04}}, sd);

    // Same-cycle succeed+fail counts as success
    send(MID, 4'd8, {8{8'h05}}, fc);
    void'(model_frame(MID, 4'd8, {8{8'h05}}, fc, pay));
    wait_strobe(8, got, sc, sd);
    chk("both_seen", 64'(got), 64'd1);
    respond("both", 1'b1, 1'b1);
    expect_none("both", RG + 20);
    check_cnt("both");

    // Frames arriving while a response is in flight: newest wins
    send(MID, 4'd8, {8{8'h06}}, fc);
    void'(model_frame(MID, 4'd8, {8{8'h06}}, fc, pay));
    wait_strobe(8, got, sc, sd);
    chk("ovw_a_seen", 64'(got), 64'd1);
    send(MID, 4'd8, {8{8'h07}}, fc);
    void'(model_frame(MID, 4'd8, {8{8'h07}}, fc, pay));
    send(MID, 4'd8, {8{8'h08}}, fc);
    void'(model_frame(MID, 4'd8, {8{8'h08}}, fc, pay));
    m_drop++;
    respond("ovw_a", 1'b1, 1'b0);
    wait_strobe(8, got, sc, sd);
    chk("ovw_c_seen", 64'(got), 64'd1);
    chk("ovw_c_data", sd, pay);
    chk("ovw_c_byte", 64'(sd[63:56]), 64'h08);
    respond("ovw_c", 1'b1, 1'b0);
    expect_none("ovw_end", 6);
    check_cnt("ovw");

    // Link timeout and resync
    repeat (T + 5) @(negedge clk);
    chk("to_alive", 64'(alive), 64'd0);
    check_cnt("to");
    errs = m_err;
    frame("resync", MID, 4'd8, {8{8'h40}}, sd);
    chk("resync_err", 64'(err_c), 64'(errs));
    chk("resync_alive", 64'(alive), 64'd1);

    // Reset right after a frame abandons its response
    send(MID, 4'd8, {8{8'h41}}, fc);
    do_reset();
    expect_none("midrst", 10);
    check_cnt("midrst");

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      int kind;
      logic [7:0]  b;
      logic [63:0] d;
      logic [3:0]  dlc;
      logic [10:0] id;
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(0, T + 10)) @(negedge clk);
      kind = $urandom_range(0, 9);
      b    = ($urandom_range(0, 4) != 0) ? 8'(m_last + 8'd1) : 8'($urandom);
      d    = {8{b}};
      dlc  = 4'd8;
      id   = MID;
      if (kind == 0) id = ($urandom_range(0, 1) != 0) ? 11'h353 : 11'($urandom_range(0, 11'h351));
      if (kind == 1) begin dlc = 4'($urandom_range(0, 15)); if (dlc == 4'd8) dlc = 4'd9; end
      if (kind == 2) d[8*$urandom_range(1, 7) +: 8] ^= 8'($urandom_range(1, 255));
      frame("rnd", id, dlc, d, sd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_seq_responder.md
Name: can_seq_responder

Overview:
- Far-end counterpart of the once-per-second CAN sequence transmitter. The transmitter sends ID 11'h352 with 8 copies of an incrementing count byte.
- This block sits beside can_simple_top on the other node and consumes its rx_data/rx_dvalid.
- It checks format and sequence continuity, keeps error counters and a link-alive watchdog, and returns one status frame per accepted frame through the tx_* strobe interface, with bounded retry on tx_failed.

Parameters:
- MATCH_ID, 11'h352, ID of frames to check; all other IDs are ignored.
- RESP_ID, 11'h353, ID driven on tx_id for response frames.
- MAX_RETRY, 3, retransmissions after the first attempt before the response is dropped.
- RETRY_GAP, 1000, idle clk_i cycles between tx_failed and the next tx_start_strobe.
- TIMEOUT_CYCLES, 100_000_000, cycles without a valid matching frame before link_alive drops (2 s at 50 MHz).

Ports:
- clk_i  in  1  system clock (50 MHz)
- rst_i  in  1  synchronous, active-high reset
- rx_data  in  80  received frame: [78:68] ID, [67:64] DLC, [63:0] data (byte0 = [7:0]); bit 79 is ignored
- rx_dvalid  in  1  one-cycle strobe; rx_data is valid in the same cycle
- tx_id  out  11  constant RESP_ID
- tx_data  out  64  response payload, registered
- tx_start_strobe  out  1  one-cycle pulse requesting transmission
- tx_succeed  in  1  one-cycle pulse, frame sent
- tx_failed  in  1  one-cycle pulse, frame failed
- seq_ok_cnt  out  16  in-sequence frames, saturating
- seq_err_cnt  out  16  sequence breaks, saturating
- fmt_err_cnt  out  16  malformed matching frames, saturating
- rsp_drop_cnt  out  16  responses lost (overwritten or retries exhausted), saturating
- last_seq  out  8  last accepted count byte
- link_alive  out  1  a valid matching frame was seen within TIMEOUT_CYCLES

Behaviour:
- Reset values:
  - All counters, last_seq, tx_data, tx_start_strobe and link_alive = 0.
  - have_seq = 0, pending = 0, FSM = IDLE.
  - Reset mid-transfer abandons the response; no strobe is issued.
- Frame check, at the edge ending the rx_dvalid cycle:
  - Only when ID == MATCH_ID.
  - Well-formed means DLC == 4'd8 and all 8 data bytes equal byte0.
  - Malformed: fmt_err_cnt++; last_seq and have_seq unchanged; no response queued.
- Sequence check, for well-formed frames:
  - If have_seq == 0: accept as sync, seq_ok_cnt++, have_seq <= 1.
  - Else if byte0 == last_seq + 1 (mod 256; 8'hFF -> 8'h00 is in sequence): seq_ok_cnt++.
  - Else: seq_err_cnt++.
  - In all three cases: last_seq <= byte0, link_alive <= 1, watchdog cleared, response queued.
- Checking and counter updates are independent of FSM state.
- Response payload, built from post-update values:
  - [63:56] = byte0; [55:48] = ~byte0.
  - [47:32] = seq_ok_cnt; [31:16] = seq_err_cnt.
  - [15:8] = fmt_err_cnt[7:0]; [7:0] = 8'hA5.
- Pending buffer:
  - Single entry.
  - Queueing while pending == 1 overwrites the entry with the newest payload and increments rsp_drop_cnt.
- FSM:
  - IDLE: if pending, load tx_data from the entry, clear pending, retry = 0, go to START.
  - START: tx_start_strobe = 1 for exactly this cycle; go to WAIT.
  - WAIT:
    - tx_succeed -> IDLE.
    - tx_failed with retry < MAX_RETRY -> retry++, go to BACKOFF.
    - tx_failed with retry == MAX_RETRY -> rsp_drop_cnt++, go to IDLE.
    - tx_succeed and tx_failed in the same cycle count as success.
  - BACKOFF: count RETRY_GAP cycles, then go to START.
  - tx_data is held stable from START until return to IDLE.
- Latency: rx_dvalid in cycle N with FSM in IDLE gives tx_start_strobe high in cycle N+2.
- Watchdog:
  - Increments every cycle when link_alive = 1.
  - On reaching TIMEOUT_CYCLES-1: link_alive <= 0, have_seq <= 0, so the next frame resyncs without a seq error.
  - A valid frame in the same cycle as timeout wins; link stays alive.
- All counters saturate at 16'hFFFF.

Decomposition:
- Package can_resp_pkg holds:
  - FSM state enum (IDLE, START, WAIT, BACKOFF).
  - rx_data field offsets and widths.
  - Response trailer constant 8'hA5.
  - A saturating-increment function.
- One natural sub-module: can_resp_tx_ctrl, containing the FSM, retry counter, backoff timer and the tx_data register. The top holds checking, counters, watchdog and the pending buffer.

Test Plan:
- Frames with byte 8'h05, 8'h06, 8'h07 after reset:
  - seq_ok_cnt = 3, seq_err_cnt = 0, last_seq = 8'h07.
  - Each gives a strobe at N+2 with tx_data = 64'h07F8_0003_0000_00A5 for the third, followed by tx_succeed.
- Sequence 8'hFE, 8'hFF, 8'h00, 8'h02: seq_ok_cnt = 3, seq_err_cnt = 1, last_seq = 8'h02.
- Matching ID with DLC = 7, or with byte3 differing: fmt_err_cnt = 1, no strobe, last_seq unchanged. ID 11'h100 frame: no effect at all.
- tx_failed after every strobe, MAX_RETRY = 3:
  - Exactly 4 strobes, each ≥ RETRY_GAP cycles after the preceding failure.
  - Then rsp_drop_cnt = 1, FSM idle.
  - Same-cycle tx_succeed + tx_failed counts as success with no retry.
- Three frames while the first response is in WAIT: rsp_drop_cnt = 1, and the next strobe carries the third frame's byte.
- TIMEOUT_CYCLES = 50 in test: no frames for 50 cycles -> link_alive = 0; next frame with byte 8'h40 counts as ok (no seq error) and raises link_alive.
